qr_row_feeder: RTL and testbench
================================

Name: qr_row_feeder

Overview:
Input staging stage directly upstream of QR_top. It captures one matrix, up to DEPTH rows of four signed 13-bit samples, from a valid/ready source into a local row buffer. It then streams the rows into QR_top's data_inA..D/last_end inputs, paced by QR_top's value (input-ready) flag. It holds the final row with last_end asserted until QR_top raises finish_out, then re-arms for the next matrix.

Parameters:
DW, 13, sample width (signed, two's complement)
DEPTH, 9, maximum rows per matrix
CW, 4, width of row counter (must hold 0..DEPTH)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  synchronous, active-low
src_valid  input  1  source row valid
src_ready  output  1  feeder can accept a row
src_a  input  DW  source column A
src_b  input  DW  source column B
src_c  input  DW  source column C
src_d  input  DW  source column D
src_last  input  1  marks final row of matrix
qr_value  input  1  QR_top value: core ready for a row
qr_finish  input  1  QR_top finish_out
data_outA  output  DW  to QR_top data_inA
data_outB  output  DW  to QR_top data_inB
data_outC  output  DW  to QR_top data_inC
data_outD  output  DW  to QR_top data_inD
last_end  output  1  to QR_top last_end
row_cnt  output  CW  rows captured in the current matrix
busy  output  1  high in any state but FILL
ovf  output  1  sticky: DEPTH rows received without src_last

Behaviour:
- Reset is sampled on the clk edge while low. All outputs reset to 0 (src_ready=0 in the reset cycle). State is FILL, wr_ptr=rd_ptr=0, ovf=0. A reset mid-stream abandons the matrix; no partial row reaches QR_top after reset.
- States: FILL, STREAM, HOLD.
- FILL:
  - src_ready=1.
  - A row is accepted on a rising edge with src_valid=1. It is written to buf[wr_ptr], and wr_ptr and row_cnt increment.
  - If the accepted row has src_last=1, or wr_ptr reaches DEPTH-1, go to STREAM at that edge. The final row's index is recorded as last_idx.
  - If DEPTH rows are accepted and none had src_last=1, set ovf=1 (sticky until reset) and treat row DEPTH-1 as last.
  - data_out*=0 and last_end=0 in this state.
- STREAM:
  - src_ready=0.
  - On each edge with qr_value=1, the output registers load buf[rd_ptr] and rd_ptr increments. Latency is one cycle: the row is visible on data_out* the cycle after qr_value is sampled.
  - On an edge with qr_value=0, the outputs load 0 (matching core expectation of zero between rows).
  - When the row at last_idx is loaded, last_end loads 1 in the same edge, and the state goes to HOLD.
- HOLD:
  - data_out* and last_end=1 hold their values every cycle regardless of qr_value.
  - On an edge with qr_finish=1, clear the outputs to 0, clear row_cnt, wr_ptr and rd_ptr, and return to FILL. src_ready rises the cycle after.
- A qr_finish seen in FILL or STREAM is ignored.
- Single-row matrix (src_last on the first row): STREAM emits one row with last_end=1 directly.
- busy = (state != FILL), registered.
- Arithmetic: rd_ptr and wr_ptr never wrap within a matrix; they reset only on qr_finish or reset. Samples pass through bit-exact, with no sign modification.

Test Plan:
1. Nine rows, row i = (i, -i, 100+i, -4096+i), src_last on row 8; qr_value held 1 -> rows appear on consecutive cycles starting the cycle after STREAM entry. last_end=1 with row 8 = (8,-8,108,-4088) and stays held; ovf=0; row_cnt=9.
2. Same nine rows, qr_value toggling 1,0,1,0 -> each row appears once, with zeros on the cycle after a qr_value=0 sample. Order is preserved; last_end asserts only with row 8.
3. In HOLD, qr_finish pulsed at cycle N -> outputs become 0 and last_end=0 at N+1, src_ready=1 at N+2. A second matrix of 3 rows ending with src_last then streams with last_end on row 2.
4. Ten rows offered with no src_last -> rows 0..8 accepted; ovf=1 and src_ready=0 after row 8; the tenth row is not accepted; last_end is asserted with row 8.
5. Reset driven low for 1 cycle during STREAM after row 3 -> all outputs 0 next cycle, state FILL, ovf=0. No further rows are emitted until a new matrix is loaded.
6. Extreme values (4095, -4096, -1, 0) in one row with src_last -> output is bit-exact, last_end=1, row_cnt=1.

Source files
------------

// File: rtl/qr_row_feeder.sv
// Input staging for QR_top: captures one matrix of up to DEPTH four-sample rows
// from a valid/ready source, then streams it row by row into the QR core.
module qr_row_feeder #(
  parameter int DW    = 13,
  parameter int DEPTH = 9,
  parameter int CW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic signed [DW-1:0] src_a,
  input  logic signed [DW-1:0] src_b,
  input  logic signed [DW-1:0] src_c,
  input  logic signed [DW-1:0] src_d,
  input  logic                 src_last,
  input  logic                 qr_value,
  input  logic                 qr_finish,
  output logic signed [DW-1:0] data_outA,
  output logic signed [DW-1:0] data_outB,
  output logic signed [DW-1:0] data_outC,
  output logic signed [DW-1:0] data_outD,
  output logic                 last_end,
  output logic [CW-1:0]        row_cnt,
  output logic                 busy,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    FILL,
    STREAM,
    HOLD
  } state_e;

  localparam int RW = 4 * DW;

  state_e          state_q, state_d;
  logic [CW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   last_idx_q, last_idx_d;
  logic [CW-1:0]   row_cnt_q, row_cnt_d;
  logic [RW-1:0]   out_q, out_d;
  logic            last_end_q, last_end_d;
  logic            src_ready_q, src_ready_d;
  logic            busy_q, busy_d;
  logic            ovf_q, ovf_d;
  logic            wr_en;
  logic [RW-1:0]   row_mem_q [DEPTH];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    last_idx_d = last_idx_q;
    row_cnt_d  = row_cnt_q;
    out_d      = out_q;
    last_end_d = last_end_q;
    ovf_d      = ovf_q;
    wr_en      = 1'b0;

    unique case (state_q)
      FILL: begin
        out_d      = '0;
        last_end_d = 1'b0;
        if (src_valid && src_ready_q) begin
          wr_en     = 1'b1;
          wr_ptr_d  = wr_ptr_q + CW'(1);
          row_cnt_d = row_cnt_q + CW'(1);
          // A full buffer without src_last is closed off as an overflowed matrix.
          if (src_last || (wr_ptr_q == CW'(DEPTH - 1))) begin
            last_idx_d = wr_ptr_q;
            state_d    = STREAM;
            if (!src_last) ovf_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (qr_value) begin
          out_d    = row_mem_q[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + CW'(1);
          if (rd_ptr_q == last_idx_q) begin
            last_end_d = 1'b1;
            state_d    = HOLD;
          end
        end else begin
          out_d = '0;
        end
      end
      HOLD: begin
        if (qr_finish) begin
          out_d      = '0;
          last_end_d = 1'b0;
          row_cnt_d  = '0;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Ready only after a full cycle in FILL, so it drops at once on leaving
    // and comes back one cycle after re-entry.
    src_ready_d = (state_d == FILL) && (state_q == FILL);
    busy_d      = (state_d != FILL);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      last_idx_q  <= '0;
      row_cnt_q   <= '0;
      out_q       <= '0;
      last_end_q  <= 1'b0;
      src_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      last_idx_q  <= last_idx_d;
      row_cnt_q   <= row_cnt_d;
      out_q       <= out_d;
      last_end_q  <= last_end_d;
      src_ready_q <= src_ready_d;
      busy_q      <= busy_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: the row buffer has no reset; a row is only read after being written
  // in the same matrix, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (wr_en) row_mem_q[wr_ptr_q] <= {src_a, src_b, src_c, src_d};
  end

  assign src_ready = src_ready_q;
  assign data_outA = out_q[4*DW-1 -: DW];
  assign data_outB = out_q[3*DW-1 -: DW];
  assign data_outC = out_q[2*DW-1 -: DW];
  assign data_outD = out_q[DW-1 -: DW];
  assign last_end  = last_end_q;
  assign row_cnt   = row_cnt_q;
  assign busy      = busy_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_qr_row_feeder.sv
// Randomized bench for qr_row_feeder against a queue-based transaction model
// of the capture / stream / hold behaviour.
module tb_qr_row_feeder;

  localparam int DW    = 13;
  localparam int DEPTH = 9;
  localparam int CW    = 4;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] a, b, c, d;
  } row_t;

  typedef enum int {M_FILL, M_STREAM, M_HOLD} m_phase_e;

  logic                 clk, reset;
  logic                 src_valid, src_ready, src_last;
  logic signed [DW-1:0] src_a, src_b, src_c, src_d;
  logic                 qr_value, qr_finish;
  logic signed [DW-1:0] data_outA, data_outB, data_outC, data_outD;
  logic                 last_end, busy, ovf;
  logic [CW-1:0]        row_cnt;

  qr_row_feeder #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_a(src_a), .src_b(src_b), .src_c(src_c), .src_d(src_d),
    .src_last(src_last), .qr_value(qr_value), .qr_finish(qr_finish),
    .data_outA(data_outA), .data_outB(data_outB),
    .data_outC(data_outC), .data_outD(data_outD),
    .last_end(last_end), .row_cnt(row_cnt), .busy(busy), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_cmp = 0;
  int    n_mis = 0;
  string cur_test = "init";

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL [%s] %s: got %0h, expected %0h", cur_test, tag, obs, exp);
    end
  endtask

  // Reference model: rows captured in this matrix, rows still to send.
  m_phase_e      m_phase = M_FILL;
  row_t          m_cap[$];
  row_t          m_send[$];
  logic [4*DW-1:0] e_out = '0;
  logic          e_last = 1'b0, e_ready = 1'b0, e_busy = 1'b0, e_ovf = 1'b0;
  int            e_cnt = 0;
  bit            m_acc = 1'b0;
  int            m_emitted = 0;

  always @(posedge clk) begin
    m_phase_e old;
    row_t     r;
    m_acc = 1'b0;
    if (!reset) begin
      m_phase = M_FILL;
      m_cap.delete();
      m_send.delete();
      e_out = '0; e_last = 1'b0; e_ready = 1'b0; e_busy = 1'b0; e_ovf = 1'b0;
      e_cnt = 0; m_emitted = 0;
    end else begin
      old = m_phase;
      case (m_phase)
        M_FILL: begin
          e_out  = '0;
          e_last = 1'b0;
          if (src_valid && e_ready) begin
            m_acc = 1'b1;
            m_cap.push_back({src_last, src_a, src_b, src_c, src_d});
            if (src_last || m_cap.size() == DEPTH) begin
              if (!src_last) e_ovf = 1'b1;
              m_send  = m_cap;
              m_phase = M_STREAM;
            end
          end
        end
        M_STREAM: begin
          if (qr_value) begin
            r = m_send.pop_front();
            e_out = {r.a, r.b, r.c, r.d};
            m_emitted++;
            if (m_send.size() == 0) begin
              e_last  = 1'b1;
              m_phase = M_HOLD;
            end
          end else begin
            e_out = '0;
          end
        end
        default: begin
          if (qr_finish) begin
            e_out  = '0;
            e_last = 1'b0;
            m_cap.delete();
            m_emitted = 0;
            m_phase = M_FILL;
          end
        end
      endcase
      e_cnt   = m_cap.size();
      e_busy  = (m_phase != M_FILL);
      e_ready = (m_phase == M_FILL) && (old == M_FILL);
    end
  end

  // Stimulus controls
  row_t src_q[$];
  int   valid_pct = 100;
  int   qv_mode   = 0;   // 0: always 1, 1: toggle 1,0,..., 2: random
  int   fin_mode  = 0;   // 0: never, 1: in HOLD randomly, 2: random any time, 3: force once
  bit   qv_tog    = 1'b0;

  function automatic logic [DW-1:0] s13(input int v);
    return v[DW-1:0];
  endfunction

  function automatic row_t mk_row(input int i, input bit last);
    row_t r;
    r.last = last;
    r.a = s13(i);
    r.b = s13(-i);
    r.c = s13(100 + i);
    r.d = s13(-4096 + i);
    return r;
  endfunction

  function automatic row_t rnd_row(input bit last);
    row_t        r;
    logic [31:0] x, y;
    x = $urandom();
    y = $urandom();
    r.last = last;
    r.a = x[12:0];
    r.b = x[25:13];
    r.c = y[12:0];
    r.d = y[25:13];
    return r;
  endfunction

  task automatic compare_all();
    check("src_ready", src_ready, e_ready);
    check("busy", busy, e_busy);
    check("ovf", ovf, e_ovf);
    check("row_cnt", row_cnt, e_cnt);
    check("last_end", last_end, e_last);
    check("data", {data_outA, data_outB, data_outC, data_outD}, e_out);
  endtask

  task automatic cycle();
    row_t idle;
    if (src_q.size() > 0 && $urandom_range(99) < valid_pct) begin
      src_valid = 1'b1;
      {src_last, src_a, src_b, src_c, src_d} = src_q[0];
    end else begin
      idle = rnd_row($urandom_range(1));
      src_valid = 1'b0;
      {src_last, src_a, src_b, src_c, src_d} = idle;
    end
    case (qv_mode)
      0:       qr_value = 1'b1;
      1:       begin qv_tog = ~qv_tog; qr_value = qv_tog; end
      default: qr_value = ($urandom_range(1) == 1);
    endcase
    case (fin_mode)
      1:       qr_finish = (m_phase == M_HOLD) && ($urandom_range(2) == 0);
      2:       qr_finish = ($urandom_range(3) == 0);
      3:       begin qr_finish = 1'b1; fin_mode = 0; end
      default: qr_finish = 1'b0;
    endcase
    @(negedge clk);
    compare_all();
    if (m_acc) void'(src_q.pop_front());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_phase(input m_phase_e tgt, input int max_cyc, input string tag);
    int n = 0;
    while (m_phase != tgt && n < max_cyc) begin
      cycle();
      n++;
    end
    check({tag, "_wait_busy"}, busy, (tgt != M_FILL));
  endtask

  task automatic release_matrix(input string tag);
    fin_mode = 1;
    wait_phase(M_FILL, 200, tag);
    fin_mode = 0;
  endtask

  task automatic load_ramp(input int n, input bit with_last);
    for (int i = 0; i < n; i++) src_q.push_back(mk_row(i, with_last && (i == n - 1)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; src_valid = 1'b0; src_last = 1'b0;
    src_a = '0; src_b = '0; src_c = '0; src_d = '0;
    qr_value = 1'b0; qr_finish = 1'b0;

    cur_test = "reset";
    run(2);
    reset = 1'b1;

    // Nine rows, qr_value held high.
    cur_test = "t1";
    qv_mode = 0; fin_mode = 0; valid_pct = 100;
    load_ramp(9, 1'b1);
    wait_phase(M_HOLD, 100, "t1");
    run(3);
    check("t1_row8", {data_outA, data_outB, data_outC, data_outD},
          {s13(8), s13(-8), s13(108), s13(-4088)});
    check("t1_last", last_end, 1);
    check("t1_ovf", ovf, 0);
    check("t1_cnt", row_cnt, 9);
    release_matrix("t1_rel");

    // Same rows, qr_value toggling.
    cur_test = "t2";
    qv_mode = 1; qv_tog = 1'b0;
    load_ramp(9, 1'b1);
    wait_phase(M_HOLD, 100, "t2");
    run(2);
    check("t2_row8", {data_outA, data_outB, data_outC, data_outD},
          {s13(8), s13(-8), s13(108), s13(-4088)});
    check("t2_last", last_end, 1);

    // Directed qr_finish pulse in HOLD, then a 3-row matrix.
    cur_test = "t3";
    qv_mode = 0;
    fin_mode = 3;
    cycle();
    check("t3_out_clr", {data_outA, data_outB, data_outC, data_outD}, 0);
    check("t3_last_clr", last_end, 0);
    check("t3_rdy_lo", src_ready, 0);
    cycle();
    check("t3_rdy_hi", src_ready, 1);
    load_ramp(3, 1'b1);
    wait_phase(M_HOLD, 100, "t3");
    check("t3_row2", {data_outA, data_outB, data_outC, data_outD},
          {s13(2), s13(-2), s13(102), s13(-4094)});
    check("t3_last", last_end, 1);
    release_matrix("t3_rel");

    // Ten rows without src_last: overflow.
    cur_test = "t4";
    load_ramp(10, 1'b0);
    wait_phase(M_HOLD, 100, "t4");
    check("t4_ovf", ovf, 1);
    check("t4_rdy", src_ready, 0);
    check("t4_cnt", row_cnt, 9);
    check("t4_row8", {data_outA, data_outB, data_outC, data_outD},
          {s13(8), s13(-8), s13(108), s13(-4088)});
    run(3);
    src_q.delete();
    release_matrix("t4_rel");

    // Reset in the middle of streaming.
    cur_test = "t5";
    load_ramp(9, 1'b1);
    begin
      int n = 0;
      while (!(m_phase == M_STREAM && m_emitted == 4) && n < 100) begin
        cycle();
        n++;
      end
      check("t5_row3_seen", {data_outA, data_outB, data_outC, data_outD},
            {s13(3), s13(-3), s13(103), s13(-4093)});
    end
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    check("t5_out0", {data_outA, data_outB, data_outC, data_outD}, 0);
    check("t5_busy0", busy, 0);
    check("t5_ovf0", ovf, 0);
    run(10);
    check("t5_idle", {data_outA, data_outB, data_outC, data_outD, last_end}, 0);

    // Extreme values in a single-row matrix.
    cur_test = "t6";
    src_q.push_back({1'b1, s13(4095), s13(-4096), s13(-1), s13(0)});
    wait_phase(M_HOLD, 100, "t6");
    check("t6_row", {data_outA, data_outB, data_outC, data_outD},
          {13'h0FFF, 13'h1000, 13'h1FFF, 13'h0000});
    check("t6_last", last_end, 1);
    check("t6_cnt", row_cnt, 1);
    release_matrix("t6_rel");

    // Random matrices with random handshakes and stray qr_finish pulses.
    cur_test = "rand";
    valid_pct = 70; qv_mode = 2;
    for (int m = 0; m < 15; m++) begin
      int len;
      len = $urandom_range(10, 1);
      for (int i = 0; i < len; i++) src_q.push_back(rnd_row((len <= DEPTH) && (i == len - 1)));
      fin_mode = 2;
      wait_phase(M_HOLD, 300, "rand_hold");
      src_q.delete();
      wait_phase(M_FILL, 300, "rand_fill");
      fin_mode = 0;
      run($urandom_range(3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
